unified_mem: RTL and testbench
==============================

# unified_mem

Word-organised unified memory model serving as both instruction memory and data memory for the 5-stage `processor`, one instance per port. It accepts one load or store command per cycle. Loads return data combinationally. Stores commit at the clock edge. Every accepted command receives a 4-bit transaction tag. Contents are preloaded hierarchically from a hex image.

## Interface
Parameters:
- `MEM_WORDS`, default 65536: number of 32-bit words; must be a power of two.
- `ADDR_W`, default 32: byte-address width.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset; synchronous and active-high.
- `proc2mem_addr`  in  32  byte address.
- `proc2mem_data`  in  32  store data.
- `proc2mem_command`  in  2  bus command: 0 = NONE, 1 = LOAD, 2 = STORE, 3 = reserved.
- `mem2proc_response`  out  4  nonzero tag when the command is accepted; 0 when rejected or idle.
- `mem2proc_data`  out  32  load data.
- `mem2proc_tag`  out  4  tag of the transaction completing this cycle.

Storage:
- Array `unified_memory [0:MEM_WORDS-1]` of 32-bit words.
- The name and layout are fixed so benches can `$readmemh` into it hierarchically.

## Operation
- Word index = `proc2mem_addr[log2(MEM_WORDS)+1:2]`. Bits [1:0] are ignored, so there are no misalignment faults.
- In range: `proc2mem_addr >> 2 < MEM_WORDS`. Out-of-range commands are rejected:
  - response 0, tag 0, data 0;
  - a store to an out-of-range address does not write.
- LOAD (in range):
  - `mem2proc_data` = `unified_memory[index]`, combinationally.
  - `mem2proc_response` = `mem2proc_tag` = current tag counter value.
- STORE (in range):
  - `unified_memory[index] <= proc2mem_data` at the rising edge.
  - response = tag = current tag; `mem2proc_data` = 0.
- NONE or reserved (3): response 0, tag 0, data 0; no state change.
- Tag counter (4 bits):
  - Range 1..15. Increments by one after each accepted command; 15 wraps to 1.
  - Never 0, so 0 unambiguously means "no transaction".
- Memory contents are not cleared by reset. This preserves preloaded program/data images.

## Timing
- Load latency is zero: data and tag are valid in the same cycle the command is presented.
- Store latency is one edge: the write is visible to a load from the next cycle onward.
- Load and store to the same index in the same cycle are impossible on a single port.
- Reset:
  - While `rst` is high at a rising edge, the tag counter is set to 1 and stores are suppressed.
  - Combinational outputs still follow the rules above. A command presented during reset reports tag 1 and is not counted.
- Reset mid-stream: the counter returns to 1 at the edge. Previously stored data is retained.
- Outputs are purely combinational from the inputs, the counter and the array. There is no hidden pipeline and no X on outputs after reset.

## Structure
- Shared package `mem_pkg`:
  - enum `bus_cmd_t` {BUS_NONE = 0, BUS_LOAD = 1, BUS_STORE = 2};
  - `MEM_WORDS` default;
  - `TAG_W = 4`.
- The processor imports the same enum to drive `im_command` (LOAD) and `proc2Dmem_command`.
- Sub-module: `mem_tag_gen`, the 1..15 wrapping counter with enable and synchronous reset. Everything else is a single always_ff write plus combinational read/decode.

## Test plan
- Preload: `$readmemh` puts 0x00500093 at word 0. Assert LOAD at addr 0x0 → data 0x00500093, response = tag = 1. A second LOAD at 0x4 → tag 2.
- Store then load: STORE 0xDEADBEEF to addr 0x100, then LOAD 0x100 next cycle → 0xDEADBEEF. Same LOAD at 0x103 → same word.
- Tag wrap: 15 consecutive LOADs after reset give tags 1..15; the 16th gives tag 1. Interleaved NONE cycles → response 0 and counter unchanged.
- Out of range with `MEM_WORDS` = 1024: STORE to 0x1000 → response 0, and LOAD 0x0 content is unchanged. LOAD 0x1000 → data 0, tag 0.
- Reserved command 3: response 0, data 0, no write, counter unchanged.
- Reset mid-stream: after tags reach 7, pulse `rst` for one edge with a STORE presented → no write, next accepted command tag 1. Preloaded and earlier stored data are intact.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared bus definitions for the processor's memory ports.
// Imported by the memory model and by the processor core.
package mem_pkg;

  localparam int DEFAULT_MEM_WORDS = 65536;
  localparam int TAG_W             = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_t;

endpackage

// File: rtl/mem_tag_gen.sv
// Transaction tag counter cycling 1..max and never producing 0, so that a
// zero tag on the bus always means "no transaction".
module mem_tag_gen
  import mem_pkg::*;
#(
  parameter int WIDTH = TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] tag
);

  localparam logic [WIDTH-1:0] TAG_FIRST = WIDTH'(1);
  localparam logic [WIDTH-1:0] TAG_LAST  = {WIDTH{1'b1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      tag <= TAG_FIRST;
    end else if (en) begin
      tag <= (tag == TAG_LAST) ? TAG_FIRST : tag + TAG_FIRST;
    end
  end

endmodule

// File: rtl/unified_mem.sv
// Word-organised memory model used for both instruction and data ports.
// Loads answer combinationally, stores commit at the clock edge.
module unified_mem
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] proc2mem_addr,
  input  logic [31:0]       proc2mem_data,
  input  logic [1:0]        proc2mem_command,
  output logic [TAG_W-1:0]  mem2proc_response,
  output logic [31:0]       mem2proc_data,
  output logic [TAG_W-1:0]  mem2proc_tag
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  // Name and shape are relied on by benches that preload images hierarchically.
  logic [31:0] unified_memory [0:MEM_WORDS-1];

  logic [ADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]  index;
  logic              in_range;
  logic              is_load;
  logic              is_store;
  logic              accepted;
  logic [TAG_W-1:0]  tag_q;
  logic [TAG_W-1:0]  cur_tag;

  assign word_addr = proc2mem_addr >> 2;
  assign index     = word_addr[IDX_W-1:0];
  assign in_range  = (word_addr < ADDR_W'(MEM_WORDS));
  assign is_load   = in_range && (proc2mem_command == BUS_LOAD);
  assign is_store  = in_range && (proc2mem_command == BUS_STORE);
  assign accepted  = is_load || is_store;

  // During reset the counter is about to become 1, so report that value now.
  assign cur_tag   = rst ? TAG_W'(1) : tag_q;

  mem_tag_gen #(
    .WIDTH (TAG_W)
  ) u_tag_gen (
    .clk (clk),
    .rst (rst),
    .en  (accepted),
    .tag (tag_q)
  );

  always_ff @(posedge clk) begin
    if (!rst && is_store) begin
      unified_memory[index] <= proc2mem_data;
    end
  end

  always_comb begin
    mem2proc_response = '0;
    mem2proc_tag      = '0;
    mem2proc_data     = '0;
    if (is_load) begin
      mem2proc_data     = unified_memory[index];
      mem2proc_response = cur_tag;
      mem2proc_tag      = cur_tag;
    end else if (is_store) begin
      mem2proc_response = cur_tag;
      mem2proc_tag      = cur_tag;
    end
  end

endmodule

// File: tb/tb_unified_mem.sv
// Randomised scoreboard bench for unified_mem with a 1024-word array, so
// out-of-range addresses are reachable.
module tb_unified_mem;

  localparam int WORDS = 1024;

  typedef struct {
    string       name;
    logic [3:0]  resp;
    logic [3:0]  tag;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [31:0] proc2mem_addr;
  logic [31:0] proc2mem_data;
  logic [1:0]  proc2mem_command;
  logic [3:0]  mem2proc_response;
  logic [31:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;

  exp_t        exp_q[$];
  logic [31:0] model_mem [0:WORDS-1];
  int          model_tag;
  int          vectors;
  int          miscompares;

  unified_mem #(
    .MEM_WORDS (WORDS),
    .ADDR_W    (32)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .proc2mem_command  (proc2mem_command),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one command just after the edge, predict the answer from the bus
  // rules, then advance the reference model as the coming edge will.
  task automatic applyStimulus(input string name, input logic r, input logic [1:0] cmd,
                               input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    logic [31:0] word;
    logic        ok;
    @(posedge clk);
    #1;
    rst              = r;
    proc2mem_command = cmd;
    proc2mem_addr    = addr;
    proc2mem_data    = wdata;
    word = addr >> 2;
    ok   = (word < WORDS) && (cmd == 2'd1 || cmd == 2'd2);
    e.name = name;
    e.resp = ok ? (r ? 4'd1 : 4'(model_tag)) : 4'd0;
    e.tag  = e.resp;
    e.data = (ok && cmd == 2'd1) ? model_mem[word[9:0]] : 32'd0;
    exp_q.push_back(e);
    if (r) begin
      model_tag = 1;
    end else if (ok) begin
      model_tag = (model_tag % 15) + 1;
      if (cmd == 2'd2) model_mem[word[9:0]] = wdata;
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors++;
    if (mem2proc_response !== e.resp || mem2proc_tag !== e.tag || mem2proc_data !== e.data) begin
      miscompares++;
      $display("[TB] FAIL %s: got resp=%0d tag=%0d data=%08h, expected resp=%0d tag=%0d data=%08h",
               e.name, mem2proc_response, mem2proc_tag, mem2proc_data, e.resp, e.tag, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) checkOutput(exp_q.pop_front());
  end

  function automatic logic [31:0] randInRange();
    return {20'd0, 10'($urandom_range(0, WORDS - 1)), 2'($urandom)};
  endfunction

  initial begin
    logic [31:0] a;
    logic [1:0]  c;
    int          budget;
    vectors          = 0;
    miscompares      = 0;
    model_tag        = 1;
    rst              = 1'b1;
    proc2mem_command = 2'd0;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;

    applyStimulus("reset_idle", 1'b1, 2'd0, 32'h0, 32'h0);
    applyStimulus("reset_idle", 1'b1, 2'd0, 32'h0, 32'h0);

    // Image load through the bus so every word has a known value.
    applyStimulus("preload", 1'b0, 2'd2, 32'h0, 32'h0050_0093);
    for (int i = 1; i < WORDS; i++)
      applyStimulus("preload", 1'b0, 2'd2, 32'(i) << 2, $urandom);

    applyStimulus("reset_idle", 1'b1, 2'd0, 32'h0, 32'h0);
    applyStimulus("load_word0_tag1", 1'b0, 2'd1, 32'h0, 32'h0);
    applyStimulus("load_word1_tag2", 1'b0, 2'd1, 32'h4, 32'h0);

    applyStimulus("store_100", 1'b0, 2'd2, 32'h100, 32'hDEAD_BEEF);
    applyStimulus("load_100", 1'b0, 2'd1, 32'h100, 32'h0);
    applyStimulus("load_103", 1'b0, 2'd1, 32'h103, 32'h0);

    applyStimulus("reset_idle", 1'b1, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus("tag_wrap_load", 1'b0, 2'd1, randInRange(), 32'h0);
      if (i % 4 == 3) applyStimulus("tag_wrap_none", 1'b0, 2'd0, randInRange(), 32'h0);
    end

    applyStimulus("oor_store", 1'b0, 2'd2, 32'h1000, 32'h1234_5678);
    applyStimulus("oor_load", 1'b0, 2'd1, 32'h1000, 32'h0);
    applyStimulus("oor_load_high", 1'b0, 2'd1, 32'hFFFF_FFFC, 32'h0);
    applyStimulus("after_oor_word0", 1'b0, 2'd1, 32'h0, 32'h0);

    applyStimulus("reserved_cmd", 1'b0, 2'd3, 32'h8, 32'hCAFE_F00D);
    applyStimulus("after_reserved", 1'b0, 2'd1, 32'h8, 32'h0);

    applyStimulus("reset_idle", 1'b1, 2'd0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++)
      applyStimulus("to_tag7", 1'b0, 2'd1, randInRange(), 32'h0);
    applyStimulus("reset_with_store", 1'b1, 2'd2, 32'h100, 32'h0BAD_0BAD);
    applyStimulus("after_reset_100", 1'b0, 2'd1, 32'h100, 32'h0);
    applyStimulus("after_reset_word0", 1'b0, 2'd1, 32'h0, 32'h0);

    for (int i = 0; i < 600; i++) begin
      c = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 9) == 0) ? ($urandom | 32'h0000_1000) : randInRange();
      applyStimulus("random", ($urandom_range(0, 39) == 0), c, a, $urandom);
    end

    applyStimulus("final_idle", 1'b0, 2'd0, 32'h0, 32'h0);
    budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
